// File: rtl/dht11_responder.sv
// dht11_responder: sensor end of the DHT11 single-wire protocol.
// Answers a host start pulse with the presence sequence, then sends a 40-bit pulse-width frame.
module dht11_responder #(
   parameter int START_MIN_CYC = 800000,
   parameter int RESP_WAIT_CYC = 1500,
   parameter int RESP_LOW_CYC  = 4000,
   parameter int RESP_HIGH_CYC = 4000,
   parameter int BIT_LOW_CYC   = 2500,
   parameter int BIT0_HIGH_CYC = 1300,
   parameter int BIT1_HIGH_CYC = 3500,
   parameter int EOT_LOW_CYC   = 2500
) (
   input  logic        clk_50MHz,
   input  logic        rst,
   inout  wire         dht_data,
   input  logic [31:0] frame_in,
   input  logic        corrupt_chk,
   output logic        busy,
   output logic        done,
   output logic        short_start,
   output logic [7:0]  frame_count
);

   function automatic int maxOf2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int MAX_CYC = maxOf2(maxOf2(maxOf2(START_MIN_CYC, RESP_WAIT_CYC),
                                          maxOf2(RESP_LOW_CYC, RESP_HIGH_CYC)),
                                   maxOf2(maxOf2(BIT_LOW_CYC, BIT0_HIGH_CYC),
                                          maxOf2(BIT1_HIGH_CYC, EOT_LOW_CYC)));
   localparam int CW = $clog2(MAX_CYC + 1);
   localparam logic [CW-1:0] START_MIN = CW'(START_MIN_CYC);

   typedef enum logic [2:0] {
      IDLE, START_LOW, WAIT, RESP_L, RESP_H, BIT_L, BIT_H, EOT
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] phase_last;
   logic          phase_end;
   logic [1:0]    sync_q;
   logic          din_s;
   logic          din_prev_q;
   logic [39:0]   shift_q, shift_d;
   logic [5:0]    idx_q, idx_d;
   logic          drive_low_q, drive_low_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          short_q, short_d;
   logic [7:0]    count_q, count_d;
   logic [7:0]    checksum;

   assign din_s       = sync_q[1];
   assign checksum    = (frame_in[31:24] + frame_in[23:16] + frame_in[15:8] + frame_in[7:0])
                        ^ {8{corrupt_chk}};
   assign dht_data    = drive_low_q ? 1'b0 : 1'bz;
   assign busy        = busy_q;
   assign done        = done_q;
   assign short_start = short_q;
   assign frame_count = count_q;

   // Terminal count of the current timed phase; a phase of N cycles ends when the counter reads N-1.
   always_comb begin
      phase_last = '0;
      case (state_q)
         WAIT:    phase_last = CW'(RESP_WAIT_CYC - 1);
         RESP_L:  phase_last = CW'(RESP_LOW_CYC - 1);
         RESP_H:  phase_last = CW'(RESP_HIGH_CYC - 1);
         BIT_L:   phase_last = CW'(BIT_LOW_CYC - 1);
         BIT_H:   phase_last = shift_q[39] ? CW'(BIT1_HIGH_CYC - 1) : CW'(BIT0_HIGH_CYC - 1);
         EOT:     phase_last = CW'(EOT_LOW_CYC - 1);
         default: phase_last = '0;
      endcase
   end

   assign phase_end = (cnt_q == phase_last);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      shift_d = shift_q;
      idx_d   = idx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      short_d = 1'b0;
      count_d = count_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (din_prev_q && !din_s) begin
               state_d = START_LOW;
               cnt_d   = CW'(1);
            end
         end
         START_LOW: begin
            if (din_s) begin
               cnt_d = '0;
               if (cnt_q >= START_MIN) begin
                  shift_d = {frame_in, checksum};
                  busy_d  = 1'b1;
                  state_d = WAIT;
               end else begin
                  short_d = 1'b1;
                  state_d = IDLE;
               end
            end else if (cnt_q >= START_MIN) begin
               cnt_d = cnt_q;
            end
         end
         WAIT: if (phase_end) begin
            cnt_d   = '0;
            state_d = RESP_L;
         end
         RESP_L: if (phase_end) begin
            cnt_d   = '0;
            state_d = RESP_H;
         end
         RESP_H: if (phase_end) begin
            cnt_d   = '0;
            idx_d   = 6'd39;
            state_d = BIT_L;
         end
         BIT_L: if (phase_end) begin
            cnt_d   = '0;
            state_d = BIT_H;
         end
         // The frame is sent MSB first by shifting left; shift_q[39] is always the current bit.
         BIT_H: if (phase_end) begin
            cnt_d   = '0;
            shift_d = {shift_q[38:0], 1'b0};
            if (idx_q == 6'd0) begin
               state_d = EOT;
            end else begin
               idx_d   = idx_q - 6'd1;
               state_d = BIT_L;
            end
         end
         EOT: if (phase_end) begin
            cnt_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            count_d = count_q + 8'd1;
            state_d = IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
      drive_low_d = (state_d == RESP_L) || (state_d == BIT_L) || (state_d == EOT);
   end

   // Synchronizer resets low so a line held low through reset is never taken as a falling edge.
   always_ff @(posedge clk_50MHz or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         sync_q      <= 2'b00;
         din_prev_q  <= 1'b0;
         shift_q     <= '0;
         idx_q       <= '0;
         drive_low_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         short_q     <= 1'b0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sync_q      <= {sync_q[0], dht_data};
         din_prev_q  <= din_s;
         shift_q     <= shift_d;
         idx_q       <= idx_d;
         drive_low_q <= drive_low_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         short_q     <= short_d;
         count_q     <= count_d;
      end
   end

endmodule

// File: tb/tb_dht11_responder.sv
// tb_dht11_responder: host side of an open-drain DHT11 line with a pull-up; every level run
// of the line is measured and matched against the waveform expected for the requested payload.
module tb_dht11_responder;

   localparam int START_MIN    = 8;
   localparam int WAIT_C       = 3;
   localparam int RESP_L_C     = 5;
   localparam int RESP_H_C     = 6;
   localparam int BIT_L_C      = 2;
   localparam int B0_C         = 1;
   localparam int B1_C         = 3;
   localparam int EOT_C        = 4;
   // Host release is 1 time unit after an edge: two synchronizer flops plus the FSM register
   // elapse before the response wait even begins.
   localparam int RELEASE_LAT  = 3;
   localparam int FRAME_BUDGET = 1000;

   typedef struct {
      logic [31:0] payload;
      logic        corrupt;
      int          lowCycles;
      logic [7:0]  chk;
      logic        accepted;
   } vec_t;

   typedef struct {
      logic level;
      int   len;
   } seg_t;

   logic        clock      = 1'b0;
   logic        rstN       = 1'b1;
   logic        hostLow    = 1'b0;
   logic [31:0] frameIn    = '0;
   logic        corruptChk = 1'b0;
   logic        busy;
   logic        done;
   logic        shortStart;
   logic [7:0]  frameCount;
   wire         dhtLine;

   assign dhtLine = hostLow ? 1'b0 : 1'bz;
   pullup (dhtLine);

   dht11_responder #(
      .START_MIN_CYC(START_MIN),
      .RESP_WAIT_CYC(WAIT_C),
      .RESP_LOW_CYC (RESP_L_C),
      .RESP_HIGH_CYC(RESP_H_C),
      .BIT_LOW_CYC  (BIT_L_C),
      .BIT0_HIGH_CYC(B0_C),
      .BIT1_HIGH_CYC(B1_C),
      .EOT_LOW_CYC  (EOT_C)
   ) dut (
      .clk_50MHz  (clock),
      .rst        (rstN),
      .dht_data   (dhtLine),
      .frame_in   (frameIn),
      .corrupt_chk(corruptChk),
      .busy       (busy),
      .done       (done),
      .short_start(shortStart),
      .frame_count(frameCount)
   );

   // 50 MHz clock, 20 time units per period
   always #10 clock = ~clock;

   seg_t        segQ[$];
   logic [39:0] frameQ[$];
   int          passCount  = 0;
   int          checkCount = 0;
   int          doneCount  = 0;
   int          shortCount = 0;
   logic        busySeen   = 1'b0;
   logic        monEnable  = 1'b1;
   logic        runValid   = 1'b0;
   logic        runLevel   = 1'b0;
   logic        lineNow;
   int          runLen     = 0;
   int          lowIdx     = 0;
   int          highIdx    = 0;
   logic [39:0] decoded    = '0;
   logic [7:0]  expFrames  = '0;
   vec_t        vecs[8];

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checkCount++;
      if (actual == expected) passCount++;
      else $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
   endtask

   function automatic logic [7:0] modelChecksum(input logic [31:0] p, input logic c);
      logic [7:0] s;
      s = p[31:24] + p[23:16] + p[15:8] + p[7:0];
      return c ? ~s : s;
   endfunction

   task automatic pushSeg(input logic level, input int len);
      seg_t s;
      s.level = level;
      s.len   = len;
      segQ.push_back(s);
   endtask

   // Expected waveform: release wait, presence low/high, 40 bits MSB first, end-of-frame low.
   task automatic pushFrame(input logic [31:0] payload, input logic [7:0] chk);
      logic [39:0] bits;
      bits = {payload, chk};
      frameQ.push_back(bits);
      pushSeg(1'b1, WAIT_C + RELEASE_LAT);
      pushSeg(1'b0, RESP_L_C);
      pushSeg(1'b1, RESP_H_C);
      for (int i = 39; i >= 0; i--) begin
         pushSeg(1'b0, BIT_L_C);
         pushSeg(1'b1, bits[i] ? B1_C : B0_C);
      end
      pushSeg(1'b0, EOT_C);
   endtask

   // A finished run is popped against the scoreboard and also decoded into frame bits.
   task automatic reportSegment();
      seg_t e;
      checkCount++;
      if (segQ.size() == 0) begin
         $display("[TB] FAIL segment: got level %0d for %0d cycles, required no activity",
                  runLevel, runLen);
      end else begin
         e = segQ.pop_front();
         if (runLevel == e.level && runLen == e.len) passCount++;
         else $display("[TB] FAIL segment: got level %0d for %0d cycles, required level %0d for %0d cycles",
                       runLevel, runLen, e.level, e.len);
      end
      if (runLevel) begin
         if (highIdx >= 2 && highIdx < 42) decoded = {decoded[38:0], (runLen > (B0_C + B1_C) / 2)};
         highIdx++;
      end else begin
         if (lowIdx == 41) begin
            if (frameQ.size() == 0) begin
               checkCount++;
               $display("[TB] FAIL decoded frame: got %010h, required no frame", decoded);
            end else begin
               checkOutput("decoded frame", decoded, frameQ.pop_front());
            end
         end
         lowIdx++;
      end
   endtask

   // Line monitor: runs are only measured while the host has released the line
   always @(negedge clock) begin
      lineNow = dhtLine;
      if (done) doneCount++;
      if (shortStart) shortCount++;
      if (busy) busySeen = 1'b1;
      if (hostLow || !monEnable) begin
         runValid = 1'b0;
         lowIdx   = 0;
         highIdx  = 0;
      end else if (!runValid) begin
         runValid = 1'b1;
         runLevel = lineNow;
         runLen   = 1;
      end else if (lineNow == runLevel) begin
         runLen++;
      end else begin
         reportSegment();
         runLevel = lineNow;
         runLen   = 1;
      end
   end

   task automatic applyStimulus(input vec_t v);
      frameIn    = v.payload;
      corruptChk = v.corrupt;
      if (v.accepted) pushFrame(v.payload, v.chk);
      @(posedge clock);
      #1 hostLow = 1'b1;
      repeat (v.lowCycles) @(posedge clock);
      #1 hostLow = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      frameIn    = $urandom;
      corruptChk = ~v.corrupt;
   endtask

   task automatic runVector(input vec_t v);
      int d0;
      int s0;
      int n;
      d0       = doneCount;
      s0       = shortCount;
      busySeen = 1'b0;
      applyStimulus(v);
      if (v.accepted) begin
         checkOutput("busy during frame", busy, 1);
         n = 0;
         while (doneCount == d0 && n < FRAME_BUDGET) begin
            @(posedge clock);
            #2;
            n++;
         end
         checkOutput("frame done within budget", doneCount != d0, 1);
         expFrames++;
         checkOutput("frame_count after frame", frameCount, expFrames);
         checkOutput("busy after frame", busy, 0);
         repeat (3) @(posedge clock);
         #2;
         checkOutput("done pulses per frame", doneCount - d0, 1);
         checkOutput("short_start quiet on valid start", shortCount - s0, 0);
      end else begin
         repeat (8) @(posedge clock);
         #2;
         checkOutput("short_start pulses", shortCount - s0, 1);
         checkOutput("busy on short start", busySeen, 0);
         checkOutput("done on short start", doneCount - d0, 0);
         checkOutput("frame_count held on short start", frameCount, expFrames);
      end
   endtask

   // Watchdog so a stuck design still ends the run
   initial begin
      #(20 * 120000);
      $display("[TB] FAIL watchdog: simulation still running, required completion");
      $fatal(1);
   end

   // Test sequence: reset state, vector table, mid-frame reset, frame counter wrap
   initial begin
      vec_t r;
      logic found;
      int   n;

      vecs[0] = '{32'h3A00_1905, 1'b0, START_MIN + 5, 8'h58, 1'b1};
      vecs[1] = '{32'h8000_0000, 1'b0, START_MIN + 1, 8'h80, 1'b1};
      vecs[2] = '{32'h0000_0000, 1'b0, START_MIN / 2, 8'h00, 1'b0};
      vecs[3] = '{32'h0102_0304, 1'b1, START_MIN,     8'hF5, 1'b1};
      vecs[4] = '{32'h0102_0304, 1'b0, START_MIN - 1, 8'h0A, 1'b0};
      vecs[5] = '{32'h0102_0304, 1'b0, START_MIN + 2, 8'h0A, 1'b1};
      vecs[6] = '{32'hFFFF_FFFF, 1'b0, START_MIN + 3, 8'hFC, 1'b1};
      vecs[7] = '{32'h0000_0000, 1'b1, START_MIN + 1, 8'hFF, 1'b1};

      #5 rstN = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      checkOutput("reset busy", busy, 0);
      checkOutput("reset done", done, 0);
      checkOutput("reset short_start", shortStart, 0);
      checkOutput("reset frame_count", frameCount, 0);
      checkOutput("reset line released", dhtLine, 1);
      rstN = 1'b1;
      repeat (6) @(posedge clock);

      for (int v = 0; v < 8; v++) runVector(vecs[v]);

      r = '{32'hA5C3_0F96, 1'b0, START_MIN + 2, 8'h0D, 1'b1};
      applyStimulus(r);
      found = 1'b0;
      n     = 0;
      while (!found && n < FRAME_BUDGET) begin
         @(posedge clock);
         #1;
         if (highIdx >= 21 && dhtLine === 1'b0) found = 1'b1;
         n++;
      end
      checkOutput("reached bit 20 preamble", found, 1);
      monEnable = 1'b0;
      segQ.delete();
      frameQ.delete();
      rstN = 1'b0;
      #1;
      checkOutput("line released by mid-frame reset", dhtLine, 1);
      checkOutput("busy after mid-frame reset", busy, 0);
      checkOutput("done after mid-frame reset", done, 0);
      checkOutput("short_start after mid-frame reset", shortStart, 0);
      checkOutput("frame_count after mid-frame reset", frameCount, 0);
      expFrames = '0;
      repeat (2) @(posedge clock);
      #1 rstN = 1'b1;
      repeat (6) @(posedge clock);
      monEnable = 1'b1;
      runVector(vecs[0]);

      for (int i = 0; i < 255; i++) begin
         r.payload   = $urandom;
         r.corrupt   = ($urandom_range(0, 3) == 0);
         r.lowCycles = START_MIN + int'($urandom_range(0, 3));
         r.chk       = modelChecksum(r.payload, r.corrupt);
         r.accepted  = 1'b1;
         runVector(r);
      end
      checkOutput("frame_count wrapped", frameCount, 0);

      checkOutput("segments left unmatched", segQ.size(), 0);
      checkOutput("frames left undecoded", frameQ.size(), 0);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
